// File: rtl/commit_trace_pkg.sv
// Shared types for the commit tracer: trace record layout, drain/halt
// state encoding, and the saturating drop-counter helper.
package commit_trace_pkg;

   localparam int CT_ADDR_W  = 64;
   localparam int CT_INST_W  = 32;
   localparam int CT_SEQ_W   = 64;
   localparam int DROP_CNT_W = 16;

   typedef struct packed {
      logic [CT_SEQ_W-1:0]  seq;
      logic [CT_ADDR_W-1:0] pc;
      logic [CT_INST_W-1:0] inst;
   } trace_entry_t;

   typedef enum logic [1:0] {
      CT_RUN    = 2'd0,
      CT_DRAIN  = 2'd1,
      CT_HALTED = 2'd2
   } ct_state_e;

   localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + DROP_ONE;
   endfunction

endpackage

// File: rtl/commit_trace_buf_if.sv
// Decode->execute issue handshake as seen by the commit tracer.
// The core side drives it (master); the tracer only observes (slave).
interface commit_trace_buf_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   logic              iss_vld;
   logic              iss_rdy;
   logic              iss_flush;
   logic [ADDR_W-1:0] iss_pc;
   logic [INST_W-1:0] iss_inst;

   modport master (
      output iss_vld, iss_rdy, iss_flush, iss_pc, iss_inst
   );

   modport slave (
      input iss_vld, iss_rdy, iss_flush, iss_pc, iss_inst
   );
endinterface

// File: rtl/ct_sync_fifo.sv
// Generic synchronous FIFO with a registered head word.
// Pointers carry one extra wrap bit so full/empty need no separate count.
// A push that is refused (full, no pop) is simply not stored; the caller
// decides what a refused push means.
module ct_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             empty_next_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] head_q, head_d;
   logic             push_ok, pop_ok;

   // Pointer arithmetic and next head word; a push landing in the slot that
   // becomes the head is forwarded so the head is valid one cycle after push.
   always_comb begin
      empty_o      = (wr_q == rd_q);
      full_o       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop_ok       = pop_i & ~empty_o;
      push_ok      = push_i & (~full_o | pop_ok);
      wr_d         = push_ok ? wr_q + PTR_ONE : wr_q;
      rd_d         = pop_ok  ? rd_q + PTR_ONE : rd_q;
      empty_next_o = (wr_d == rd_d);
      if (empty_next_o) begin
         head_d = '0;
      end else if (push_ok && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
         head_d = wdata_i;
      end else begin
         head_d = mem_q[rd_d[AW-1:0]];
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_q[AW-1:0]] <= wdata_i;
      end
   end

   // Pointers and registered head, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         head_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         head_q <= head_d;
      end
   end

   assign head_o = head_q;

endmodule

// File: rtl/commit_trace_buf.sv
// Commit tracer: records every accepted, non-flushed issue as a
// {seq, pc, inst} entry for the trace consumer, counts commits and
// overflow losses, and sequences RUN -> DRAIN -> HALTED on ebreak.
module commit_trace_buf
   import commit_trace_pkg::*;
#(
   parameter int ADDR_W = CT_ADDR_W,
   parameter int INST_W = CT_INST_W,
   parameter int DEPTH  = 16,
   parameter int SEQ_W  = CT_SEQ_W
) (
   input  logic                  clk,
   input  logic                  rst,
   commit_trace_buf_if.slave     iss,
   input  logic                  ebreak_i,
   input  logic                  pop_i,
   output logic                  head_vld_o,
   output logic [SEQ_W-1:0]      head_seq_o,
   output logic [ADDR_W-1:0]     head_pc_o,
   output logic [INST_W-1:0]     head_inst_o,
   output logic [SEQ_W-1:0]      commit_cnt_o,
   output logic [DROP_CNT_W-1:0] drop_cnt_o,
   output logic                  ovf_o,
   output logic                  halt_o
);
   localparam int ENT_W = SEQ_W + ADDR_W + INST_W;
   localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

   ct_state_e             state_q;
   logic                  halt_q;
   logic [SEQ_W-1:0]      commit_q;
   logic [DROP_CNT_W-1:0] drop_q;
   logic                  ovf_q;

   logic                  capture;
   logic                  drop;
   logic [ENT_W-1:0]      wentry;
   logic [ENT_W-1:0]      hentry;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_empty_next;

   // Capture qualification; a capture into a full FIFO with no pop is a drop.
   always_comb begin
      capture = iss.iss_vld & iss.iss_rdy & ~iss.iss_flush & (state_q == CT_RUN);
      drop    = capture & fifo_full & ~(pop_i & ~fifo_empty);
      wentry  = {commit_q, iss.iss_pc, iss.iss_inst};
   end

   ct_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (capture),
      .wdata_i      (wentry),
      .pop_i        (pop_i),
      .head_o       (hentry),
      .empty_o      (fifo_empty),
      .full_o       (fifo_full),
      .empty_next_o (fifo_empty_next)
   );

   // Commit count (dropped entries included, so seq gaps expose loss),
   // saturating drop count and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         commit_q <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (capture) begin
            commit_q <= commit_q + SEQ_ONE;
         end
         if (drop) begin
            drop_q <= drop_sat_inc(drop_q);
            ovf_q  <= 1'b1;
         end
      end
   end

   // Halt sequencer: ebreak stops capture, halt rises once the queue has
   // been fully drained (checked against the post-pop occupancy).
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= CT_RUN;
         halt_q  <= 1'b0;
      end else begin
         case (state_q)
            CT_RUN: begin
               if (ebreak_i) begin
                  state_q <= CT_DRAIN;
               end
            end
            CT_DRAIN: begin
               if (fifo_empty_next) begin
                  state_q <= CT_HALTED;
                  halt_q  <= 1'b1;
               end
            end
            CT_HALTED: begin
               halt_q <= 1'b1;
            end
            default: begin
               state_q <= CT_RUN;
               halt_q  <= 1'b0;
            end
         endcase
      end
   end

   assign head_vld_o   = ~fifo_empty;
   assign head_seq_o   = hentry[ENT_W-1 -: SEQ_W];
   assign head_pc_o    = hentry[ADDR_W+INST_W-1 -: ADDR_W];
   assign head_inst_o  = hentry[INST_W-1:0];
   assign commit_cnt_o = commit_q;
   assign drop_cnt_o   = drop_q;
   assign ovf_o        = ovf_q;
   assign halt_o       = halt_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf: directed table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_commit_trace_buf;
   import commit_trace_pkg::*;

   localparam int DEPTH = 16;

   logic        clk;
   logic        rst;
   logic        ebreak_i;
   logic        pop_i;
   logic        head_vld_o;
   logic [63:0] head_seq_o;
   logic [63:0] head_pc_o;
   logic [31:0] head_inst_o;
   logic [63:0] commit_cnt_o;
   logic [15:0] drop_cnt_o;
   logic        ovf_o;
   logic        halt_o;

   commit_trace_buf_if #(.ADDR_W(64), .INST_W(32)) bus ();

   commit_trace_buf #(
      .ADDR_W (64),
      .INST_W (32),
      .DEPTH  (DEPTH),
      .SEQ_W  (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .iss          (bus),
      .ebreak_i     (ebreak_i),
      .pop_i        (pop_i),
      .head_vld_o   (head_vld_o),
      .head_seq_o   (head_seq_o),
      .head_pc_o    (head_pc_o),
      .head_inst_o  (head_inst_o),
      .commit_cnt_o (commit_cnt_o),
      .drop_cnt_o   (drop_cnt_o),
      .ovf_o        (ovf_o),
      .halt_o       (halt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: plain queue of trace records plus flags.
   trace_entry_t mq[$];
   logic [63:0]  m_cnt;
   int           m_drop;
   bit           m_ovf;
   bit           m_ebk;
   bit           m_halt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cnt  = 0;
      m_drop = 0;
      m_ovf  = 0;
      m_ebk  = 0;
      m_halt = 0;
   endtask

   task automatic model_update(input bit r, input bit vld, input bit rdy, input bit fl,
                               input logic [63:0] pc, input logic [31:0] inst,
                               input bit eb, input bit pop);
      bit cap;
      bit was_ebk;
      if (!r) begin
         model_reset();
      end else begin
         cap     = vld && rdy && !fl && !m_ebk;
         was_ebk = m_ebk;
         if (pop && mq.size() > 0) void'(mq.pop_front());
         if (cap) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(trace_entry_t'{seq: m_cnt, pc: pc, inst: inst});
            end else begin
               m_ovf = 1;
               if (m_drop < 65535) m_drop++;
            end
            m_cnt = m_cnt + 64'd1;
         end
         if (was_ebk && mq.size() == 0) m_halt = 1;
         if (eb) m_ebk = 1;
      end
   endtask

   task automatic check_model();
      bit          e_vld;
      logic [63:0] e_seq, e_pc;
      logic [31:0] e_inst;
      e_vld  = (mq.size() > 0);
      e_seq  = e_vld ? mq[0].seq  : 64'd0;
      e_pc   = e_vld ? mq[0].pc   : 64'd0;
      e_inst = e_vld ? mq[0].inst : 32'd0;
      chk("head_vld",   {63'd0, head_vld_o}, {63'd0, e_vld});
      chk("head_seq",   head_seq_o, e_seq);
      chk("head_pc",    head_pc_o, e_pc);
      chk("head_inst",  {32'd0, head_inst_o}, {32'd0, e_inst});
      chk("commit_cnt", commit_cnt_o, m_cnt);
      chk("drop_cnt",   {48'd0, drop_cnt_o}, 64'(m_drop));
      chk("ovf",        {63'd0, ovf_o}, {63'd0, m_ovf});
      chk("halt",       {63'd0, halt_o}, {63'd0, m_halt});
   endtask

   // One clock: drive on the falling edge, update model at the rising edge,
   // compare shortly after it.
   task automatic step(input bit r, input bit vld, input bit rdy, input bit fl,
                       input logic [63:0] pc, input logic [31:0] inst,
                       input bit eb, input bit pop);
      @(negedge clk);
      rst           = r;
      bus.iss_vld   = vld;
      bus.iss_rdy   = rdy;
      bus.iss_flush = fl;
      bus.iss_pc    = pc;
      bus.iss_inst  = inst;
      ebreak_i      = eb;
      pop_i         = pop;
      @(posedge clk);
      model_update(r, vld, rdy, fl, pc, inst, eb, pop);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 64'd0, 32'd0, 0, 0);
   endtask

   task automatic push(input logic [63:0] pc);
      step(1, 1, 1, 0, pc, pc[31:0] ^ 32'h0000_0013, 0, 0);
   endtask

   task automatic idle(input bit pop);
      step(1, 0, 0, 0, 64'd0, 32'd0, 0, pop);
   endtask

   typedef struct {
      bit          vld;
      bit          pop;
      logic [63:0] pc;
      logic [31:0] inst;
      bit          exp_vld;
      logic [63:0] exp_seq;
      logic [63:0] exp_pc;
      logic [63:0] exp_cnt;
   } vec_t;

   vec_t tbl[10];

   initial begin
      rst = 0; ebreak_i = 0; pop_i = 0;
      bus.iss_vld = 0; bus.iss_rdy = 0; bus.iss_flush = 0;
      bus.iss_pc = '0; bus.iss_inst = '0;

      // Five captures then five pops; expected values are post-edge outputs.
      for (int k = 0; k < 5; k++) begin
         tbl[k] = '{vld: 1, pop: 0, pc: 64'h8000_0000 + 64'(4 * k),
                    inst: 32'h0000_0013 | (k << 7), exp_vld: 1, exp_seq: 64'd0,
                    exp_pc: 64'h8000_0000, exp_cnt: 64'(k + 1)};
      end
      for (int j = 0; j < 5; j++) begin
         tbl[5 + j] = '{vld: 0, pop: 1, pc: 64'd0, inst: 32'd0,
                        exp_vld: (j < 4), exp_seq: (j < 4) ? 64'(j + 1) : 64'd0,
                        exp_pc: (j < 4) ? 64'h8000_0000 + 64'(4 * (j + 1)) : 64'd0,
                        exp_cnt: 64'd5};
      end

      do_reset();
      do_reset();
      chk("reset_cnt", commit_cnt_o, 64'd0);
      chk("reset_vld", {63'd0, head_vld_o}, 64'd0);

      // Test 1: table-driven in-order capture and drain.
      for (int i = 0; i < 10; i++) begin
         step(1, tbl[i].vld, tbl[i].vld, 0, tbl[i].pc, tbl[i].inst, 0, tbl[i].pop);
         chk("t1_vld", {63'd0, head_vld_o}, {63'd0, tbl[i].exp_vld});
         chk("t1_seq", head_seq_o, tbl[i].exp_seq);
         chk("t1_pc",  head_pc_o,  tbl[i].exp_pc);
         chk("t1_cnt", commit_cnt_o, tbl[i].exp_cnt);
      end

      // Test 2: overflow, then capture+pop while full.
      do_reset();
      for (int k = 0; k < 20; k++) push(64'h8000_0000 + 64'(4 * k));
      chk("t2_ovf",  {63'd0, ovf_o}, 64'd1);
      chk("t2_drop", {48'd0, drop_cnt_o}, 64'd4);
      chk("t2_cnt",  commit_cnt_o, 64'd20);
      step(1, 1, 1, 0, 64'h9000_0000, 32'h0010_0073, 0, 1);
      chk("t2_drop_fullpop", {48'd0, drop_cnt_o}, 64'd4);
      chk("t2_cnt_fullpop",  commit_cnt_o, 64'd21);
      chk("t2_head_fullpop", head_seq_o, 64'd1);
      for (int k = 0; k < 17; k++) idle(1);
      chk("t2_drained", {63'd0, head_vld_o}, 64'd0);

      // Test 3: flush kills the third of four issues.
      do_reset();
      for (int k = 0; k < 4; k++) step(1, 1, 1, (k == 2), 64'h100 + 64'(4 * k), 32'h13, 0, 0);
      chk("t3_cnt", commit_cnt_o, 64'd3);
      for (int k = 0; k < 3; k++) begin
         chk("t3_seq", head_seq_o, 64'(k));
         idle(1);
      end
      chk("t3_empty", {63'd0, head_vld_o}, 64'd0);

      // Test 4: ebreak with three entries queued.
      do_reset();
      for (int k = 0; k < 3; k++) push(64'h2000 + 64'(4 * k));
      step(1, 0, 0, 0, 64'd0, 32'd0, 1, 0);
      push(64'h3000);
      push(64'h3004);
      chk("t4_cnt", commit_cnt_o, 64'd3);
      idle(1);
      chk("t4_halt_pop1", {63'd0, halt_o}, 64'd0);
      idle(1);
      chk("t4_halt_pop2", {63'd0, halt_o}, 64'd0);
      idle(1);
      chk("t4_halt_pop3", {63'd0, halt_o}, 64'd1);
      step(1, 1, 1, 0, 64'h4000, 32'h13, 1, 1);
      idle(0);
      chk("t4_halt_sticky", {63'd0, halt_o}, 64'd1);
      chk("t4_cnt_after",   commit_cnt_o, 64'd3);

      // Test 5: ebreak on empty FIFO, then reset and resume.
      do_reset();
      step(1, 0, 0, 0, 64'd0, 32'd0, 1, 0);
      chk("t5_halt_c1", {63'd0, halt_o}, 64'd0);
      idle(0);
      chk("t5_halt_c2", {63'd0, halt_o}, 64'd1);
      do_reset();
      chk("t5_halt_rst", {63'd0, halt_o}, 64'd0);
      push(64'h5000);
      chk("t5_seq0", head_seq_o, 64'd0);
      chk("t5_vld",  {63'd0, head_vld_o}, 64'd1);

      // Test 6: reset mid-burst with eight entries and overflow flagged.
      do_reset();
      for (int k = 0; k < 20; k++) push(64'h6000 + 64'(4 * k));
      for (int k = 0; k < 8; k++) idle(1);
      chk("t6_ovf_pre", {63'd0, ovf_o}, 64'd1);
      step(0, 1, 1, 0, 64'h7000, 32'h13, 0, 0);
      chk("t6_vld",  {63'd0, head_vld_o}, 64'd0);
      chk("t6_ovf",  {63'd0, ovf_o}, 64'd0);
      chk("t6_drop", {48'd0, drop_cnt_o}, 64'd0);

      // Randomized run against the model, alternating fill-heavy and
      // drain-heavy phases so overflow and empty both occur.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         bit r, v, y, f, e, p;
         int pop_pct;
         pop_pct = ((i / 300) % 2 == 0) ? 15 : 75;
         r = ($urandom_range(499) != 0);
         v = ($urandom_range(99) < 70);
         y = ($urandom_range(99) < 80);
         f = ($urandom_range(7) == 0);
         e = ($urandom_range(249) == 0);
         p = ($urandom_range(99) < pop_pct);
         if (m_halt && $urandom_range(19) == 0) r = 0;
         step(r, v, y, f, {$urandom, $urandom}, $urandom, e, p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
